// File: rtl/sound_mailbox_pkg.sv
// Shared definitions for the sound_mailbox block.
//   nmi_state_t   : states of the sound-NMI pulse generator
//   CTRL_*        : bit positions in the main-side control byte
//   MST_* / SST_* : bit positions in main_status / snd_status
package sound_mailbox_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } nmi_state_t;

   // Control register bits written through main_din on main_ctrl_wr
   localparam int CTRL_RUN   = 0;
   localparam int CTRL_IRQEN = 1;

   // main_status = {overrun, cmd_full, resp_full}
   localparam int MST_RESP_FULL = 0;
   localparam int MST_CMD_FULL  = 1;
   localparam int MST_OVERRUN   = 2;

   // snd_status = {cmd_full, resp_full}
   localparam int SST_RESP_FULL = 0;
   localparam int SST_CMD_FULL  = 1;

endpackage

// File: rtl/sound_mailbox_nmi_pulse_gen.sv
// NMI pulse generator for the sound 6502.
// A request produces a low pulse of exactly NMI_WIDTH cycles followed by at
// least one high cycle. Requests that arrive while a pulse or its trailing
// gap is in progress are remembered as a single pending pulse.
// Ports:
//   phi0     : clock
//   rst_b    : synchronous active-low reset
//   req      : one-cycle pulse request
//   flush    : abort everything, force SNDNMI_b high, drop pending request
//   SNDNMI_b : registered NMI output, active low
module nmi_pulse_gen #(
   parameter int NMI_WIDTH = 4
) (
   input  logic phi0,
   input  logic rst_b,
   input  logic req,
   input  logic flush,
   output logic SNDNMI_b
);
   import sound_mailbox_pkg::*;

   localparam int CNT_W = $clog2(NMI_WIDTH + 1);
   // The first low cycle is entered on the load edge, so count NMI_WIDTH-1 more
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(NMI_WIDTH - 1);

   nmi_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pending_q;
   logic             nmi_b_q;

   always_ff @(posedge phi0) begin
      if (!rst_b || flush) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         nmi_b_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  state_q <= PULSE;
                  cnt_q   <= PULSE_LOAD;
                  nmi_b_q <= 1'b0;
               end
            end
            PULSE: begin
               // A new request never stretches the running pulse
               if (req) begin
                  pending_q <= 1'b1;
               end
               if (cnt_q == '0) begin
                  state_q <= GAP;
                  nmi_b_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            GAP: begin
               // A request landing on the gap edge merges with any pending one
               if (pending_q || req) begin
                  state_q   <= PULSE;
                  cnt_q     <= PULSE_LOAD;
                  nmi_b_q   <= 1'b0;
                  pending_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               nmi_b_q <= 1'b1;
            end
         endcase
      end
   end

   assign SNDNMI_b = nmi_b_q;

endmodule

// File: rtl/sound_mailbox.sv
// Command/response mailbox between the main CPU bus and the sound board.
// Main side posts a command byte (raises an NMI to the sound 6502), sound
// side posts a response byte (raises a maskable IRQ to the main CPU), and a
// main-side control register holds the sound board in reset.
// Ports:
//   phi0, rst_b                : clock, synchronous active-low reset
//   main_din, main_cmd_wr      : command write from main CPU
//   main_ctrl_wr               : control write, din[0]=snd_run, din[1]=irq_en
//   main_resp_rd               : main CPU consumes response
//   main_resp, main_status     : response latch, {overrun,cmd_full,resp_full}
//   main_irq                   : response-available IRQ to main CPU
//   snd_din, snd_resp_wr       : response write from sound 6502
//   snd_cmd_rd                 : sound 6502 consumes command
//   snd_cmd, snd_status        : command latch, {cmd_full,resp_full}
//   SNDNMI_b, SNDRST_b         : NMI and reset to the sound board, active low
module sound_mailbox #(
   parameter int NMI_WIDTH = 4,
   parameter int RST_HOLD  = 8
) (
   input  logic       phi0,
   input  logic       rst_b,
   input  logic [7:0] main_din,
   input  logic       main_cmd_wr,
   input  logic       main_ctrl_wr,
   input  logic       main_resp_rd,
   output logic [7:0] main_resp,
   output logic [2:0] main_status,
   output logic       main_irq,
   input  logic [7:0] snd_din,
   input  logic       snd_resp_wr,
   input  logic       snd_cmd_rd,
   output logic [7:0] snd_cmd,
   output logic [1:0] snd_status,
   output logic       SNDNMI_b,
   output logic       SNDRST_b
);
   import sound_mailbox_pkg::*;

   localparam int HOLD_W = $clog2(RST_HOLD + 1);

   logic [7:0]        cmd_q, cmd_d;
   logic [7:0]        resp_q, resp_d;
   logic              cmd_full_q, cmd_full_d;
   logic              resp_full_q, resp_full_d;
   logic              overrun_q, overrun_d;
   logic              snd_run_q, snd_run_d;
   logic              irq_en_q, irq_en_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              snd_rst_b_q, snd_rst_b_d;
   logic              main_irq_q, main_irq_d;
   logic              active;
   logic              nmi_req;

   always_comb begin
      snd_run_d = snd_run_q;
      irq_en_d  = irq_en_q;
      if (main_ctrl_wr) begin
         snd_run_d = main_din[CTRL_RUN];
         irq_en_d  = main_din[CTRL_IRQEN];
      end

      // The mailbox only runs when the sound board is out of reset both now
      // and after this edge, so stopping takes effect on the same edge.
      active = snd_run_q & snd_run_d;

      cmd_d       = cmd_q;
      resp_d      = resp_q;
      cmd_full_d  = cmd_full_q;
      resp_full_d = resp_full_q;
      overrun_d   = overrun_q;

      if (!active) begin
         cmd_full_d  = 1'b0;
         resp_full_d = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         if (main_cmd_wr) begin
            cmd_d      = main_din;
            cmd_full_d = 1'b1;
            if (cmd_full_q && !snd_cmd_rd) begin
               overrun_d = 1'b1;
            end
         end else if (snd_cmd_rd) begin
            cmd_full_d = 1'b0;
            overrun_d  = 1'b0;
         end

         if (snd_resp_wr) begin
            resp_d      = snd_din;
            resp_full_d = 1'b1;
         end else if (main_resp_rd) begin
            resp_full_d = 1'b0;
         end
      end

      // Reset-release hold: reload while stopped, count down once running
      hold_d = hold_q;
      if (!snd_run_q) begin
         hold_d = HOLD_W'(RST_HOLD);
      end else if (hold_q != '0) begin
         hold_d = hold_q - HOLD_W'(1);
      end
      snd_rst_b_d = snd_run_d & snd_run_q & (hold_q == '0);

      // Registered from next-state values so the IRQ tracks resp_full exactly
      main_irq_d = resp_full_d & irq_en_d;
   end

   always_ff @(posedge phi0) begin
      if (!rst_b) begin
         cmd_q       <= '0;
         resp_q      <= '0;
         cmd_full_q  <= 1'b0;
         resp_full_q <= 1'b0;
         overrun_q   <= 1'b0;
         snd_run_q   <= 1'b0;
         irq_en_q    <= 1'b0;
         hold_q      <= HOLD_W'(RST_HOLD);
         snd_rst_b_q <= 1'b0;
         main_irq_q  <= 1'b0;
      end else begin
         cmd_q       <= cmd_d;
         resp_q      <= resp_d;
         cmd_full_q  <= cmd_full_d;
         resp_full_q <= resp_full_d;
         overrun_q   <= overrun_d;
         snd_run_q   <= snd_run_d;
         irq_en_q    <= irq_en_d;
         hold_q      <= hold_d;
         snd_rst_b_q <= snd_rst_b_d;
         main_irq_q  <= main_irq_d;
      end
   end

   assign nmi_req = active & main_cmd_wr;

   nmi_pulse_gen #(
      .NMI_WIDTH (NMI_WIDTH)
   ) u_nmi (
      .phi0     (phi0),
      .rst_b    (rst_b),
      .req      (nmi_req),
      .flush    (~active),
      .SNDNMI_b (SNDNMI_b)
   );

   assign main_resp                  = resp_q;
   assign snd_cmd                    = cmd_q;
   assign main_status[MST_OVERRUN]   = overrun_q;
   assign main_status[MST_CMD_FULL]  = cmd_full_q;
   assign main_status[MST_RESP_FULL] = resp_full_q;
   assign snd_status[SST_CMD_FULL]   = cmd_full_q;
   assign snd_status[SST_RESP_FULL]  = resp_full_q;
   assign main_irq                   = main_irq_q;
   assign SNDRST_b                   = snd_rst_b_q;

endmodule

// File: tb/tb_sound_mailbox.sv
// Self-checking bench for sound_mailbox. The driver applies one cycle of
// stimulus, advances a behavioural model and queues the expected outputs;
// the monitor pops one expectation per cycle and compares it with the DUT.
// The NMI line is modelled as a queue of future output levels and the reset
// release as elapsed time since snd_run was set.
module tb_sound_mailbox;

   localparam int NMI_WIDTH = 4;
   localparam int RST_HOLD  = 8;

   logic       phi0 = 1'b0;
   logic       rst_b = 1'b0;
   logic [7:0] main_din = '0;
   logic       main_cmd_wr = 1'b0;
   logic       main_ctrl_wr = 1'b0;
   logic       main_resp_rd = 1'b0;
   logic [7:0] main_resp;
   logic [2:0] main_status;
   logic       main_irq;
   logic [7:0] snd_din = '0;
   logic       snd_resp_wr = 1'b0;
   logic       snd_cmd_rd = 1'b0;
   logic [7:0] snd_cmd;
   logic [1:0] snd_status;
   logic       SNDNMI_b;
   logic       SNDRST_b;

   always #5 phi0 = ~phi0;

   sound_mailbox #(
      .NMI_WIDTH (NMI_WIDTH),
      .RST_HOLD  (RST_HOLD)
   ) dut (
      .phi0         (phi0),
      .rst_b        (rst_b),
      .main_din     (main_din),
      .main_cmd_wr  (main_cmd_wr),
      .main_ctrl_wr (main_ctrl_wr),
      .main_resp_rd (main_resp_rd),
      .main_resp    (main_resp),
      .main_status  (main_status),
      .main_irq     (main_irq),
      .snd_din      (snd_din),
      .snd_resp_wr  (snd_resp_wr),
      .snd_cmd_rd   (snd_cmd_rd),
      .snd_cmd      (snd_cmd),
      .snd_status   (snd_status),
      .SNDNMI_b     (SNDNMI_b),
      .SNDRST_b     (SNDRST_b)
   );

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] resp;
      logic [2:0] mst;
      logic [1:0] sst;
      logic       irq;
      logic       nmi_b;
      logic       snd_rst;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Behavioural model state
   logic [7:0] m_cmd, m_resp;
   bit         m_cmd_full, m_resp_full, m_ovr, m_run, m_irqen;
   int         run_since;
   bit         nmi_sched[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge();
      exp_t e;
      bit   prev_run;
      bit   act;
      cyc++;
      if (!rst_b) begin
         m_cmd = '0; m_resp = '0;
         m_cmd_full = 0; m_resp_full = 0; m_ovr = 0;
         m_run = 0; m_irqen = 0; run_since = 0;
         nmi_sched.delete();
      end else begin
         prev_run = m_run;
         if (main_ctrl_wr) begin
            m_run   = main_din[0];
            m_irqen = main_din[1];
            if (!prev_run && m_run) run_since = cyc;
         end
         act = prev_run && m_run;
         if (!act) begin
            m_cmd_full = 0; m_resp_full = 0; m_ovr = 0;
            nmi_sched.delete();
         end else begin
            if (main_cmd_wr) begin
               if (m_cmd_full && !snd_cmd_rd) m_ovr = 1;
               m_cmd = main_din;
               m_cmd_full = 1;
               // Queue a pulse unless one is already waiting to start
               if (nmi_sched.size() < NMI_WIDTH + 1) begin
                  repeat (NMI_WIDTH) nmi_sched.push_back(1'b0);
                  nmi_sched.push_back(1'b1);
               end
            end else if (snd_cmd_rd) begin
               m_cmd_full = 0;
               m_ovr = 0;
            end
            if (snd_resp_wr) begin
               m_resp = snd_din;
               m_resp_full = 1;
            end else if (main_resp_rd) begin
               m_resp_full = 0;
            end
         end
      end
      e.cmd     = m_cmd;
      e.resp    = m_resp;
      e.mst     = {m_ovr, m_cmd_full, m_resp_full};
      e.sst     = {m_cmd_full, m_resp_full};
      e.irq     = m_resp_full & m_irqen;
      e.nmi_b   = (nmi_sched.size() == 0) ? 1'b1 : nmi_sched.pop_front();
      e.snd_rst = m_run && ((cyc - run_since) >= RST_HOLD + 1);
      exp_q.push_back(e);
   endtask

   task automatic step(input bit rb, input bit cw, input bit ctw, input bit rr,
                       input bit rw, input bit cr, input logic [7:0] md,
                       input logic [7:0] sd);
      @(negedge phi0);
      rst_b        = rb;
      main_cmd_wr  = cw;
      main_ctrl_wr = ctw;
      main_resp_rd = rr;
      snd_resp_wr  = rw;
      snd_cmd_rd   = cr;
      main_din     = md;
      snd_din      = sd;
      @(posedge phi0);
      model_edge();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
   endtask

   // Monitor: one expectation per clock, sampled on the falling edge
   always @(negedge phi0) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("snd_cmd",     snd_cmd,            mon_e.cmd);
         chk("main_resp",   main_resp,          mon_e.resp);
         chk("main_status", 8'(main_status),    8'(mon_e.mst));
         chk("snd_status",  8'(snd_status),     8'(mon_e.sst));
         chk("main_irq",    8'(main_irq),       8'(mon_e.irq));
         chk("SNDNMI_b",    8'(SNDNMI_b),       8'(mon_e.nmi_b));
         chk("SNDRST_b",    8'(SNDRST_b),       8'(mon_e.snd_rst));
      end
   end

   initial begin
      logic [7:0] md;
      bit cw, ctw, rr, rw, cr;

      // 1: reset, then release the sound board with IRQs enabled
      repeat (3) step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      idle(2);
      step(1, 0, 1, 0, 0, 0, 8'h03, 8'h00);
      idle(12);
      // 2: single command, NMI pulse, sound reads it
      step(1, 1, 0, 0, 0, 0, 8'h5A, 8'h00);
      idle(6);
      step(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
      idle(2);
      // 3: two commands back to back -> overrun and a second pulse
      step(1, 1, 0, 0, 0, 0, 8'h11, 8'h00);
      idle(1);
      step(1, 1, 0, 0, 0, 0, 8'h22, 8'h00);
      idle(12);
      step(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
      idle(1);
      // 4: response with IRQ, then simultaneous read and write
      step(1, 0, 0, 0, 1, 0, 8'h00, 8'hC3);
      idle(1);
      step(1, 0, 0, 1, 1, 0, 8'h00, 8'h3C);
      idle(1);
      step(1, 0, 0, 1, 0, 0, 8'h00, 8'h00);
      idle(1);
      // 5: write and read in the same cycle while full
      step(1, 1, 0, 0, 0, 0, 8'h33, 8'h00);
      idle(8);
      step(1, 1, 0, 0, 0, 1, 8'h77, 8'h00);
      idle(6);
      // 6: stop the sound board in the middle of a pulse
      step(1, 1, 0, 0, 1, 0, 8'h44, 8'h99);
      step(1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
      step(1, 1, 0, 0, 1, 0, 8'h55, 8'h66);
      idle(3);
      step(1, 0, 1, 0, 0, 0, 8'h03, 8'h00);
      idle(12);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         md  = 8'($urandom);
         cw  = ($urandom_range(0, 5) == 0);
         ctw = ($urandom_range(0, 59) == 0);
         rr  = ($urandom_range(0, 5) == 0);
         rw  = ($urandom_range(0, 6) == 0);
         cr  = ($urandom_range(0, 7) == 0);
         if (ctw) md[0] = ($urandom_range(0, 9) != 0);
         step(1, cw, ctw, rr, rw, cr, md, 8'($urandom));
      end
      idle(4);

      repeat (2) @(negedge phi0);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
